// File: rtl/block128_unpack_pkg.sv
// Shared sizes and FSM encoding for the 128-bit block to byte-stream unpacker.
package block128_unpack_pkg;

  localparam int BLOCK_W         = 128;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 16;
  localparam int FIFO_DEPTH      = 2;
  localparam int OCC_W           = 2;
  localparam int IDX_W           = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/block_fifo2.sv
// Two-entry FIFO of 128-bit blocks; the head entry is always visible on head.
module block_fifo2
  import block128_unpack_pkg::*;
(
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [BLOCK_W-1:0] push_data,
  output logic [BLOCK_W-1:0] head,
  output logic [OCC_W-1:0]   occupancy
);

  logic [BLOCK_W-1:0] mem [FIFO_DEPTH];
  logic               wr_ptr;
  logic               rd_ptr;
  logic               do_push;
  logic               do_pop;

  // When full, a push is only legal alongside a pop; it reuses the slot being freed.
  assign do_pop  = pop && (occupancy != '0);
  assign do_push = push && ((occupancy != OCC_W'(FIFO_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/block128_unpack.sv
// Serializes 128-bit blocks into a valid/ready byte stream through a 2-deep block FIFO.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready; byte_valid never drops without a transfer.
module block128_unpack
  import block128_unpack_pkg::*;
#(
  parameter int MSB_FIRST = 1
) (
  input  logic               sclk,
  input  logic               rst_n,
  input  logic [BLOCK_W-1:0] data128,
  input  logic               data128_en,
  output logic [BYTE_W-1:0]  byte_data,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               byte_first,
  output logic               byte_last,
  output logic               fifo_full,
  output logic [7:0]         drop_cnt,
  output state_t             state_dbg
);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   sel;
  logic [BLOCK_W-1:0] head;
  logic [OCC_W-1:0]   occupancy;
  logic               xfer;
  logic               pop;
  logic               accept;
  logic               drop;

  block_fifo2 u_fifo (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .push      (accept),
    .pop       (pop),
    .push_data (data128),
    .head      (head),
    .occupancy (occupancy)
  );

  assign fifo_full  = (occupancy == OCC_W'(FIFO_DEPTH));
  assign byte_valid = (state == ST_SEND);
  assign xfer       = byte_valid && byte_ready;
  assign pop        = xfer && (idx == IDX_W'(BYTES_PER_BLOCK - 1));
  // A full FIFO still takes a block on the edge that releases the head.
  assign accept     = data128_en && (!fifo_full || pop);
  assign drop       = data128_en && fifo_full && !pop;
  assign state_dbg  = state;

  assign sel        = (MSB_FIRST != 0) ? (IDX_W'(BYTES_PER_BLOCK - 1) - idx) : idx;
  assign byte_data  = byte_valid ? head[{sel, 3'b000} +: BYTE_W] : '0;
  assign byte_first = byte_valid && (idx == '0);
  assign byte_last  = byte_valid && (idx == IDX_W'(BYTES_PER_BLOCK - 1));

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      drop_cnt <= '0;
    end else begin
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (accept) begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            idx <= idx + IDX_W'(1);
          end
          if (pop && (occupancy == OCC_W'(1)) && !accept) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block128_unpack.sv
// Directed bench for block128_unpack: both byte orders, stalls, FIFO overflow and mid-block reset.
module tb_block128_unpack;
  import block128_unpack_pkg::*;

  logic               sclk;
  logic               rst_n;
  logic [BLOCK_W-1:0] data128;
  logic               data128_en;
  logic               byte_ready;

  logic [BYTE_W-1:0]  byte_data,  l_byte_data;
  logic               byte_valid, l_byte_valid;
  logic               byte_first, l_byte_first;
  logic               byte_last,  l_byte_last;
  logic               fifo_full,  l_fifo_full;
  logic [7:0]         drop_cnt,   l_drop_cnt;
  state_t             state_dbg,  l_state_dbg;

  int check_cnt;
  int error_cnt;

  block128_unpack #(.MSB_FIRST(1)) dut (
    .sclk(sclk), .rst_n(rst_n), .data128(data128), .data128_en(data128_en),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_first(byte_first), .byte_last(byte_last), .fifo_full(fifo_full),
    .drop_cnt(drop_cnt), .state_dbg(state_dbg)
  );

  block128_unpack #(.MSB_FIRST(0)) dut_lsb (
    .sclk(sclk), .rst_n(rst_n), .data128(data128), .data128_en(data128_en),
    .byte_data(l_byte_data), .byte_valid(l_byte_valid), .byte_ready(byte_ready),
    .byte_first(l_byte_first), .byte_last(l_byte_last), .fifo_full(l_fifo_full),
    .drop_cnt(l_drop_cnt), .state_dbg(l_state_dbg)
  );

  // Clock / reset
  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  // Block whose transmit-order bytes (MSB first) are base, base+1, ... base+15.
  function automatic logic [BLOCK_W-1:0] make_blk(input logic [7:0] base);
    logic [BLOCK_W-1:0] b;
    b = '0;
    for (int i = 0; i < BYTES_PER_BLOCK; i++) b[(15-i)*8 +: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic test_reset;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    tick; tick;
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL reset_valid got=%b exp=0", byte_valid); end
    check_cnt++; if (byte_data !== 8'h00) begin error_cnt++; $display("FAIL reset_data got=%h exp=00", byte_data); end
    check_cnt++; if ({byte_first, byte_last} !== 2'b00) begin error_cnt++; $display("FAIL reset_first_last got=%b exp=00", {byte_first, byte_last}); end
    check_cnt++; if (fifo_full !== 1'b0) begin error_cnt++; $display("FAIL reset_full got=%b exp=0", fifo_full); end
    check_cnt++; if (drop_cnt !== 8'd0) begin error_cnt++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    check_cnt++; if (state_dbg !== ST_IDLE) begin error_cnt++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    byte_ready = 1'b1;
    data128 = make_blk(8'h00);
    data128_en = 1'b1;
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL single_pre_valid got=%b exp=0", byte_valid); end
    tick;
    data128_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if (byte_valid !== 1'b1 || byte_data !== 8'(i) || byte_first !== (i == 0) || byte_last !== (i == 15)) begin
        error_cnt++;
        $display("FAIL single_byte%0d got v=%b d=%h f=%b l=%b exp v=1 d=%h f=%b l=%b",
                 i, byte_valid, byte_data, byte_first, byte_last, 8'(i), (i == 0), (i == 15));
      end
      tick;
    end
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL single_idle got=%b exp=0", byte_valid); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b;
    byte_ready = 1'b1;
    data128 = make_blk(8'h00);
    data128_en = 1'b1;
    tick;
    for (int k = 0; k < 32; k++) begin
      if (k == 0) data128 = make_blk(8'h10);
      exp_b = 8'(k);
      check_cnt++;
      if (byte_valid !== 1'b1 || byte_data !== exp_b || byte_first !== (k % 16 == 0) || byte_last !== (k % 16 == 15)) begin
        error_cnt++;
        $display("FAIL b2b_byte%0d got v=%b d=%h f=%b l=%b exp d=%h", k, byte_valid, byte_data, byte_first, byte_last, exp_b);
      end
      tick;
      data128_en = 1'b0;
    end
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL b2b_idle got=%b exp=0", byte_valid); end
    check_cnt++; if (drop_cnt !== 8'd0) begin error_cnt++; $display("FAIL b2b_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_stall;
    logic pat [4];
    int n;
    int c;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    byte_ready = 1'b1;
    data128 = make_blk(8'h50);
    data128_en = 1'b1;
    tick;
    data128_en = 1'b0;
    n = 0;
    c = 0;
    while (n < 16 && c < 100) begin
      byte_ready = pat[c % 4];
      check_cnt++;
      if (byte_valid !== 1'b1 || byte_data !== 8'h50 + 8'(n) || byte_first !== (n == 0) || byte_last !== (n == 15) || fifo_full !== 1'b0) begin
        error_cnt++;
        $display("FAIL stall_cycle%0d got v=%b d=%h f=%b l=%b full=%b exp d=%h", c, byte_valid, byte_data, byte_first, byte_last, fifo_full, 8'h50 + 8'(n));
      end
      tick;
      if (byte_ready) n++;
      c++;
    end
    check_cnt++; if (n != 16) begin error_cnt++; $display("FAIL stall_timeout got=%0d bytes exp=16", n); end
    byte_ready = 1'b1;
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL stall_idle got=%b exp=0", byte_valid); end
  endtask

  task automatic test_drop;
    logic [7:0] exp_b;
    byte_ready = 1'b0;
    data128_en = 1'b1;
    data128 = make_blk(8'h20);
    tick;
    data128 = make_blk(8'h40);
    tick;
    check_cnt++; if (fifo_full !== 1'b1) begin error_cnt++; $display("FAIL drop_full2 got=%b exp=1", fifo_full); end
    data128 = make_blk(8'h60);
    tick;
    data128_en = 1'b0;
    check_cnt++; if (drop_cnt !== 8'd1) begin error_cnt++; $display("FAIL drop_cnt1 got=%0d exp=1", drop_cnt); end
    check_cnt++; if (byte_data !== 8'h20 || byte_first !== 1'b1) begin error_cnt++; $display("FAIL drop_head_held got d=%h f=%b exp d=20 f=1", byte_data, byte_first); end
    byte_ready = 1'b1;
    for (int i = 0; i < 15; i++) tick;
    check_cnt++; if (byte_last !== 1'b1 || byte_data !== 8'h2F) begin error_cnt++; $display("FAIL drop_last got l=%b d=%h exp l=1 d=2f", byte_last, byte_data); end
    data128_en = 1'b1;
    data128 = make_blk(8'h80);
    tick;
    data128_en = 1'b0;
    check_cnt++; if (drop_cnt !== 8'd1) begin error_cnt++; $display("FAIL drop_coincident got=%0d exp=1", drop_cnt); end
    check_cnt++; if (fifo_full !== 1'b1) begin error_cnt++; $display("FAIL drop_full_after_swap got=%b exp=1", fifo_full); end
    for (int k = 0; k < 32; k++) begin
      exp_b = (k < 16) ? 8'h40 + 8'(k) : 8'h80 + 8'(k - 16);
      check_cnt++;
      if (byte_valid !== 1'b1 || byte_data !== exp_b || byte_first !== (k % 16 == 0)) begin
        error_cnt++;
        $display("FAIL drop_drain%0d got v=%b d=%h f=%b exp d=%h", k, byte_valid, byte_data, byte_first, exp_b);
      end
      tick;
    end
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL drop_idle got=%b exp=0", byte_valid); end
  endtask

  task automatic test_reset_mid;
    byte_ready = 1'b1;
    data128_en = 1'b1;
    data128 = make_blk(8'h00);
    tick;
    data128 = make_blk(8'h10);
    tick;
    data128_en = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    check_cnt++; if (byte_data !== 8'h07 || fifo_full !== 1'b1) begin error_cnt++; $display("FAIL rmid_pre got d=%h full=%b exp d=07 full=1", byte_data, fifo_full); end
    rst_n = 1'b0;
    #1;
    check_cnt++; if (byte_valid !== 1'b0 || byte_data !== 8'h00) begin error_cnt++; $display("FAIL rmid_async got v=%b d=%h exp v=0 d=00", byte_valid, byte_data); end
    check_cnt++; if (fifo_full !== 1'b0 || drop_cnt !== 8'd0) begin error_cnt++; $display("FAIL rmid_clear got full=%b drop=%0d exp 0 0", fifo_full, drop_cnt); end
    tick; tick;
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL rmid_hold got=%b exp=0", byte_valid); end
    rst_n = 1'b1;
    data128_en = 1'b1;
    data128 = make_blk(8'hC0);
    tick;
    data128_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if (byte_valid !== 1'b1 || byte_data !== 8'hC0 + 8'(i) || byte_first !== (i == 0)) begin
        error_cnt++;
        $display("FAIL rmid_new%0d got v=%b d=%h f=%b exp d=%h", i, byte_valid, byte_data, byte_first, 8'hC0 + 8'(i));
      end
      tick;
    end
    check_cnt++; if (byte_valid !== 1'b0) begin error_cnt++; $display("FAIL rmid_idle got=%b exp=0", byte_valid); end
  endtask

  task automatic test_lsb_first;
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < 16; i++) b[i*8 +: 8] = 8'(i);
    byte_ready = 1'b1;
    data128 = b;
    data128_en = 1'b1;
    tick;
    data128_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if (l_byte_valid !== 1'b1 || l_byte_data !== 8'(i) || l_byte_first !== (i == 0) || l_byte_last !== (i == 15)) begin
        error_cnt++;
        $display("FAIL lsb_byte%0d got v=%b d=%h f=%b l=%b exp d=%h", i, l_byte_valid, l_byte_data, l_byte_first, l_byte_last, 8'(i));
      end
      check_cnt++;
      if (byte_data !== 8'(15 - i)) begin
        error_cnt++;
        $display("FAIL lsb_msb_ref%0d got=%h exp=%h", i, byte_data, 8'(15 - i));
      end
      tick;
    end
    check_cnt++; if (l_byte_valid !== 1'b0) begin error_cnt++; $display("FAIL lsb_idle got=%b exp=0", l_byte_valid); end
  endtask

  initial begin
    check_cnt  = 0;
    error_cnt  = 0;
    rst_n      = 1'b1;
    data128    = '0;
    data128_en = 1'b0;
    byte_ready = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_stall;
    test_drop;
    test_reset_mid;
    test_lsb_first;
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule

// File: doc/block128_unpack.md
BLOCK128_UNPACK -- requirements
Module: block128_unpack

Interface
REQ-001 Parameter: MSB_FIRST, default 1, byte order (1 = bits 127:120 first; 0 = bits 7:0 first).
REQ-002 sclk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 data128  input  128  block to serialize; sampled only when data128_en=1.
REQ-005 data128_en  input  1  one-cycle block-valid strobe; no back-pressure toward the producer.
REQ-006 byte_data  output  8  current output byte.
REQ-007 byte_valid  output  1  byte_data holds a valid byte.
REQ-008 byte_ready  input  1  consumer accepts byte; transfer = byte_valid & byte_ready.
REQ-009 byte_first  output  1  qualifies byte 0 of a block (valid only with byte_valid).
REQ-010 byte_last  output  1  qualifies byte 15 of a block (valid only with byte_valid).
REQ-011 fifo_full  output  1  both block slots occupied.
REQ-012 drop_cnt  output  8  count of blocks dropped due to full FIFO; saturates at 255.

Function
REQ-013 Storage SHALL be a 2-entry FIFO of 128-bit blocks; the head entry is the block being serialized.
REQ-014 occupancy SHALL range 0..2; fifo_full = (occupancy==2).
REQ-015 A strobe with occupancy<2 SHALL write data128 to the tail entry at that edge.
REQ-016 A strobe with occupancy==2 and no same-cycle head release SHALL be discarded and increment drop_cnt (saturating at 255).
REQ-017 A strobe with occupancy==2 in the same cycle that the head's byte 15 transfers SHALL be accepted; no drop.
REQ-018 FSM states: IDLE (occupancy 0, byte_valid=0) and SEND (byte_valid=1).
REQ-019 IDLE->SEND SHALL occur on the edge that writes a block into an empty FIFO; byte_valid rises the next cycle (latency 1 from data128_en).
REQ-020 In SEND, a 4-bit index idx (0..15) SHALL select byte_data from the head; with MSB_FIRST=1, byte_data = head[127-8*idx -: 8].
REQ-021 byte_data, byte_first, byte_last SHALL be held stable while byte_valid=1 and byte_ready=0.
REQ-022 On each transfer, idx SHALL increment; on the transfer at idx=15, idx wraps to 0 and the head pops.
REQ-023 After the pop, SEND SHALL remain with no bubble if occupancy>0, else go to IDLE (byte_valid=0 the next cycle).
REQ-024 byte_first = byte_valid & (idx==0); byte_last = byte_valid & (idx==15).
REQ-025 Sustained throughput SHALL be 1 byte/cycle with byte_ready held high.
REQ-026 byte_ready without byte_valid SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL immediately clear occupancy, idx, FSM (IDLE), byte_data=0, byte_valid=0, byte_first=0, byte_last=0, fifo_full=0, drop_cnt=0.
REQ-028 Reset mid-block SHALL discard all queued and partial blocks with no trailing bytes after release.
REQ-029 A data128_en during the first edge after rst_n deasserts SHALL be accepted normally.

Structure
REQ-030 Shared package SHALL hold BLOCK_W=128, BYTE_W=8, BYTES_PER_BLOCK=16, FIFO_DEPTH=2 and the FSM state encoding.
REQ-031 One sub-module, block_fifo2 (2x128 FIFO with push/pop/occupancy), SHALL be used; the FSM, byte mux and drop counter reside in the top module.

Verification
REQ-032 Single block 0x000102...0F, MSB_FIRST=1, byte_ready=1 -> bytes 00..0F on 16 consecutive cycles starting 1 cycle after the strobe; byte_first on 00, byte_last on 0F.
REQ-033 Two blocks strobed 1 cycle apart, byte_ready=1 -> 32 consecutive bytes, no bubble, drop_cnt=0.
REQ-034 byte_ready toggled 1,0,0,1 repeating -> byte_data stable through stalls, all 16 bytes in order, fifo_full=0.
REQ-035 byte_ready=0, three strobes -> fifo_full=1 after the second, drop_cnt=1; strobe coincident with the byte-15 transfer of head -> accepted, drop_cnt unchanged.
REQ-036 rst_n pulsed low at idx=7 with 1 block queued -> byte_valid=0 immediately, no further bytes; a new block after release starts at byte_first.
REQ-037 MSB_FIRST=0, block 0x0F0E...00 -> output bytes 00..0F.
